// File: rtl/key_voice_regs.sv
// Key/voice register file on an Avalon-MM slave.
// Global registers are written straight through to the live outputs. Voice fields go to a shadow
// bank, which is copied to the live bank on the first sample tick after a COMMIT.
module key_voice_regs #(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned ADDR_W     = 7
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [ADDR_W-1:0]        AVL_ADDR,
  input  logic [3:0]               AVL_BYTE_EN,
  input  logic                     AVL_READ,
  input  logic                     AVL_WRITE,
  input  logic                     AVL_CS,
  input  logic [31:0]              AVL_WRITEDATA,
  output logic [31:0]              AVL_READDATA,
  output logic                     AVL_READDATAVALID,
  input  logic                     SAMPLE_TICK,
  output logic [16*32-1:0]         GLOBAL_REG,
  output logic [NUM_VOICES-1:0]    KEY,
  output logic [7*NUM_VOICES-1:0]  FREQ,
  output logic [16*NUM_VOICES-1:0] AMP0,
  output logic [16*NUM_VOICES-1:0] AMP1,
  output logic                     APPLY_PULSE
);

  localparam int unsigned VselW = ADDR_W - 2;

  logic [15:0][31:0]            glob_q, glob_d;
  logic [NUM_VOICES-1:0]        sh_key_q, sh_key_d, lv_key_q, lv_key_d;
  logic [NUM_VOICES-1:0][6:0]   sh_freq_q, sh_freq_d, lv_freq_q, lv_freq_d;
  logic [NUM_VOICES-1:0][15:0]  sh_amp0_q, sh_amp0_d, lv_amp0_q, lv_amp0_d;
  logic [NUM_VOICES-1:0][15:0]  sh_amp1_q, sh_amp1_d, lv_amp1_q, lv_amp1_d;
  logic                         pending_q, pending_d;
  logic [7:0]                   cnt_q, cnt_d;
  logic [31:0]                  rdata_q, rdata_d;
  logic                         rvalid_q, rvalid_d;
  logic                         apply_q, apply_d;

  logic             wr_en, rd_en, apply;
  logic             glob_hit, commit_hit, status_hit, voice_hit;
  logic [VselW-1:0] vsel;
  logic [1:0]       fsel;
  logic [31:0]      cur_word, wr_word;

  assign wr_en      = AVL_WRITE & AVL_CS;
  assign rd_en      = AVL_READ & AVL_CS;
  assign apply      = pending_q & SAMPLE_TICK;
  assign glob_hit   = AVL_ADDR < ADDR_W'(16);
  assign commit_hit = AVL_ADDR == ADDR_W'(16);
  assign status_hit = AVL_ADDR == ADDR_W'(17);
  // Voice region starts at word 32, i.e. quad 8; each voice owns one quad.
  assign vsel       = AVL_ADDR[ADDR_W-1:2] - VselW'(8);
  assign fsel       = AVL_ADDR[1:0];
  assign voice_hit  = (AVL_ADDR >= ADDR_W'(32)) && (vsel < VselW'(NUM_VOICES));

  // Current (pre-write) value of the addressed register, zero-extended.
  always_comb begin
    cur_word = '0;
    if (glob_hit) begin
      cur_word = glob_q[AVL_ADDR[3:0]];
    end else if (status_hit) begin
      cur_word = {16'h0, cnt_q, 7'h0, pending_q};
    end else if (voice_hit) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        if (vsel == VselW'(v)) begin
          case (fsel)
            2'd0:    cur_word = {31'h0, sh_key_q[v]};
            2'd1:    cur_word = {25'h0, sh_freq_q[v]};
            2'd2:    cur_word = {16'h0, sh_amp0_q[v]};
            default: cur_word = {16'h0, sh_amp1_q[v]};
          endcase
        end
      end
    end
  end

  // Byte-enable merge of write data over the current value.
  always_comb begin
    wr_word = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (AVL_BYTE_EN[b]) wr_word[8*b +: 8] = AVL_WRITEDATA[8*b +: 8];
    end
  end

  // Next-state: apply copies the pre-write shadow; a write in the same cycle lands afterwards.
  always_comb begin
    glob_d    = glob_q;
    sh_key_d  = sh_key_q;
    sh_freq_d = sh_freq_q;
    sh_amp0_d = sh_amp0_q;
    sh_amp1_d = sh_amp1_q;
    lv_key_d  = lv_key_q;
    lv_freq_d = lv_freq_q;
    lv_amp0_d = lv_amp0_q;
    lv_amp1_d = lv_amp1_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    apply_d   = apply;
    rvalid_d  = rd_en;
    rdata_d   = rd_en ? cur_word : rdata_q;

    if (apply) begin
      lv_key_d  = sh_key_q;
      lv_freq_d = sh_freq_q;
      lv_amp0_d = sh_amp0_q;
      lv_amp1_d = sh_amp1_q;
      pending_d = 1'b0;
      cnt_d     = cnt_q + 8'd1;
    end

    if (wr_en) begin
      if (glob_hit) glob_d[AVL_ADDR[3:0]] = wr_word;
      // Cancel wins over set within one COMMIT write.
      if (commit_hit && AVL_BYTE_EN[0]) begin
        if (AVL_WRITEDATA[1])      pending_d = 1'b0;
        else if (AVL_WRITEDATA[0]) pending_d = 1'b1;
      end
      if (voice_hit) begin
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
          if (vsel == VselW'(v)) begin
            case (fsel)
              2'd0:    sh_key_d[v]  = wr_word[0];
              2'd1:    sh_freq_d[v] = wr_word[6:0];
              2'd2:    sh_amp0_d[v] = wr_word[15:0];
              default: sh_amp1_d[v] = wr_word[15:0];
            endcase
          end
        end
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      glob_q    <= '0;
      sh_key_q  <= '0;
      sh_freq_q <= '0;
      sh_amp0_q <= '0;
      sh_amp1_q <= '0;
      lv_key_q  <= '0;
      lv_freq_q <= '0;
      lv_amp0_q <= '0;
      lv_amp1_q <= '0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      apply_q   <= 1'b0;
    end else begin
      glob_q    <= glob_d;
      sh_key_q  <= sh_key_d;
      sh_freq_q <= sh_freq_d;
      sh_amp0_q <= sh_amp0_d;
      sh_amp1_q <= sh_amp1_d;
      lv_key_q  <= lv_key_d;
      lv_freq_q <= lv_freq_d;
      lv_amp0_q <= lv_amp0_d;
      lv_amp1_q <= lv_amp1_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      apply_q   <= apply_d;
    end
  end

  assign AVL_READDATA      = rdata_q;
  assign AVL_READDATAVALID = rvalid_q;
  assign APPLY_PULSE       = apply_q;
  assign GLOBAL_REG        = glob_q;
  assign KEY               = lv_key_q;
  assign FREQ              = lv_freq_q;
  assign AMP0              = lv_amp0_q;
  assign AMP1              = lv_amp1_q;

endmodule

// File: tb/tb_key_voice_regs.sv
// Bench for key_voice_regs: register table, directed commit/apply sequences, random traffic
// checked every cycle against a register-map model.
module tb_key_voice_regs;

  localparam int NV = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [6:0]    AVL_ADDR;
  logic [3:0]    AVL_BYTE_EN;
  logic          AVL_READ, AVL_WRITE, AVL_CS;
  logic [31:0]   AVL_WRITEDATA;
  logic [31:0]   AVL_READDATA;
  logic          AVL_READDATAVALID;
  logic          SAMPLE_TICK;
  logic [511:0]  GLOBAL_REG;
  logic [NV-1:0] KEY;
  logic [7*NV-1:0]  FREQ;
  logic [16*NV-1:0] AMP0, AMP1;
  logic          APPLY_PULSE;

  always #5 CLK = ~CLK;

  key_voice_regs #(.NUM_VOICES(NV), .ADDR_W(7)) dut (
    .CLK(CLK), .RESET(RESET), .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN),
    .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
    .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
    .AVL_READDATAVALID(AVL_READDATAVALID), .SAMPLE_TICK(SAMPLE_TICK),
    .GLOBAL_REG(GLOBAL_REG), .KEY(KEY), .FREQ(FREQ), .AMP0(AMP0), .AMP1(AMP1),
    .APPLY_PULSE(APPLY_PULSE)
  );

  int n_chk = 0;
  int n_err = 0;

  // Model: register map as plain arrays indexed [voice][field].
  bit [31:0] m_glob [16];
  bit [31:0] m_sh [NV][4];
  bit [31:0] m_lv [NV][4];
  bit        m_pend, m_rvalid, m_apply;
  int        m_cnt;
  bit [31:0] m_rdata;
  bit [31:0] fmask [4] = '{32'h1, 32'h7F, 32'hFFFF, 32'hFFFF};

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit [31:0] m_read(input int a);
    if (a < 16) return m_glob[a];
    if (a == 17) return {16'h0, 8'(m_cnt), 7'h0, m_pend};
    if (a >= 32 && (a - 32) / 4 < NV) return m_sh[(a - 32) / 4][a % 4];
    return 32'h0;
  endfunction

  task automatic m_step(input bit rst, cs, rd, wr, tick, input int a, input bit [3:0] be,
                        input bit [31:0] wd);
    bit [31:0] cur, bm;
    if (rst) begin
      foreach (m_glob[g]) m_glob[g] = 0;
      for (int v = 0; v < NV; v++) for (int f = 0; f < 4; f++) begin
        m_sh[v][f] = 0;
        m_lv[v][f] = 0;
      end
      m_pend = 0; m_cnt = 0; m_rdata = 0; m_rvalid = 0; m_apply = 0;
      return;
    end
    cur = m_read(a);
    m_apply = m_pend && tick;
    if (m_apply) begin
      for (int v = 0; v < NV; v++) for (int f = 0; f < 4; f++) m_lv[v][f] = m_sh[v][f];
      m_cnt = (m_cnt + 1) % 256;
      m_pend = 0;
    end
    m_rvalid = cs && rd;
    if (m_rvalid) m_rdata = cur;
    if (cs && wr) begin
      bm = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      if (a < 16) m_glob[a] = (cur & ~bm) | (wd & bm);
      else if (a == 16 && be[0]) begin
        if (wd[1]) m_pend = 0;
        else if (wd[0]) m_pend = 1;
      end else if (a >= 32 && (a - 32) / 4 < NV)
        m_sh[(a - 32) / 4][a % 4] = ((cur & ~bm) | (wd & bm)) & fmask[a % 4];
    end
  endtask

  // One clock: drive, advance model, sample #1 after the edge and compare all outputs.
  task automatic step(input bit rst, cs, rd, wr, tick, input int a, input bit [3:0] be,
                      input bit [31:0] wd);
    logic [511:0] eg;
    logic [NV-1:0] ek;
    logic [7*NV-1:0] ef;
    logic [16*NV-1:0] ea0, ea1;
    RESET = rst; AVL_CS = cs; AVL_READ = rd; AVL_WRITE = wr; SAMPLE_TICK = tick;
    AVL_ADDR = 7'(a); AVL_BYTE_EN = be; AVL_WRITEDATA = wd;
    m_step(rst, cs, rd, wr, tick, a, be, wd);
    @(posedge CLK);
    #1;
    for (int g = 0; g < 16; g++) eg[g*32 +: 32] = m_glob[g];
    for (int v = 0; v < NV; v++) begin
      ek[v]          = m_lv[v][0][0];
      ef[v*7 +: 7]   = m_lv[v][1][6:0];
      ea0[v*16 +: 16] = m_lv[v][2][15:0];
      ea1[v*16 +: 16] = m_lv[v][3][15:0];
    end
    chk("rvalid", 512'(AVL_READDATAVALID), 512'(m_rvalid));
    chk("rdata", 512'(AVL_READDATA), 512'(m_rdata));
    chk("apply", 512'(APPLY_PULSE), 512'(m_apply));
    chk("global", GLOBAL_REG, eg);
    chk("key", 512'(KEY), 512'(ek));
    chk("freq", 512'(FREQ), 512'(ef));
    chk("amp0", 512'(AMP0), 512'(ea0));
    chk("amp1", 512'(AMP1), 512'(ea1));
  endtask

  task automatic wr(input int a, input bit [3:0] be, input bit [31:0] d);
    step(0, 1, 0, 1, 0, a, be, d);
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 4'h0, 32'h0);
  endtask
  task automatic rd_chk(input int a, input logic [31:0] exp, input string nm);
    step(0, 1, 1, 0, 0, a, 4'h0, 32'h0);
    chk(nm, 512'(AVL_READDATA), 512'(exp));
    chk({nm, "_valid"}, 512'(AVL_READDATAVALID), 512'(1'b1));
  endtask

  typedef struct {
    int          addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{3,  4'b0101, 32'hAABBCCDD, 32'h00BB00DD};
    tbl[1] = '{5,  4'b1111, 32'h12345678, 32'h12345678};
    tbl[2] = '{33, 4'b1111, 32'hFFFFFFFF, 32'h0000007F};
    tbl[3] = '{34, 4'b0011, 32'hDEADBEEF, 32'h0000BEEF};
    tbl[4] = '{35, 4'b1100, 32'hDEADBEEF, 32'h00000000};
    tbl[5] = '{32, 4'b1111, 32'h00000003, 32'h00000001};
    tbl[6] = '{17, 4'b1111, 32'hFFFFFFFF, 32'h00000000};
    tbl[7] = '{48, 4'b1111, 32'hFFFFFFFF, 32'h00000000};
    tbl[8] = '{16, 4'b0000, 32'h00000001, 32'h00000000};
    tbl[9] = '{47, 4'b1111, 32'h0001ABCD, 32'h0000ABCD};

    step(1, 0, 0, 0, 0, 0, 4'h0, 32'h0);
    step(1, 1, 1, 1, 1, 3, 4'hF, 32'hFFFFFFFF);
    idle();
    chk("reset_global", GLOBAL_REG, 512'h0);
    chk("reset_rvalid", 512'(AVL_READDATAVALID), 512'h0);

    // Register table: write then read back.
    for (int i = 0; i < 10; i++) begin
      wr(tbl[i].addr, tbl[i].be, tbl[i].wd);
      rd_chk(tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d", i));
      idle();
      chk($sformatf("tbl%0d_hold", i), 512'(AVL_READDATA), 512'(tbl[i].exp));
    end
    chk("global3_live", 512'(GLOBAL_REG[3*32 +: 32]), 512'(32'h00BB00DD));

    // Shadow then commit, tick five cycles later.
    wr(41, 4'hF, 32'h45);
    wr(40, 4'hF, 32'h1);
    chk("freq2_shadowed", 512'(FREQ[14 +: 7]), 512'h0);
    chk("key2_shadowed", 512'(KEY[2]), 512'h0);
    wr(16, 4'hF, 32'h1);
    for (int i = 0; i < 4; i++) idle();
    chk("no_apply_yet", 512'(APPLY_PULSE), 512'h0);
    step(0, 0, 0, 0, 1, 0, 4'h0, 32'h0);
    chk("apply_pulse", 512'(APPLY_PULSE), 512'h1);
    chk("freq2_live", 512'(FREQ[14 +: 7]), 512'h45);
    chk("key2_live", 512'(KEY[2]), 512'h1);
    idle();
    chk("apply_single", 512'(APPLY_PULSE), 512'h0);
    rd_chk(17, 32'h00000100, "status_cnt1");

    // COMMIT with tick in the same cycle, then a voice write on the applying tick.
    wr(38, 4'hF, 32'h1111);
    step(0, 1, 0, 1, 1, 16, 4'hF, 32'h1);
    chk("commit_tick_no_apply", 512'(APPLY_PULSE), 512'h0);
    rd_chk(17, 32'h00000101, "status_pending");
    step(0, 1, 0, 1, 1, 38, 4'hF, 32'h2222);
    chk("apply2_pulse", 512'(APPLY_PULSE), 512'h1);
    chk("amp0_1_old", 512'(AMP0[16 +: 16]), 512'h1111);
    rd_chk(38, 32'h00002222, "amp0_1_shadow_new");
    rd_chk(17, 32'h00000200, "status_cnt2");

    // Cancel priority, then counter wrap from reset.
    wr(16, 4'hF, 32'h3);
    rd_chk(17, 32'h00000200, "cancel_no_pending");
    step(1, 0, 0, 0, 0, 0, 4'h0, 32'h0);
    for (int i = 0; i < 256; i++) begin
      wr(16, 4'h1, 32'h1);
      step(0, 0, 0, 0, 1, 0, 4'h0, 32'h0);
    end
    rd_chk(17, 32'h00000000, "cnt_wrap");

    // Reset with a pending apply and a concurrent tick and write.
    wr(45, 4'hF, 32'h7F);
    wr(16, 4'hF, 32'h1);
    rd_chk(17, 32'h00000001, "pending_before_reset");
    step(1, 1, 1, 1, 1, 3, 4'hF, 32'hFFFFFFFF);
    chk("reset_no_apply", 512'(APPLY_PULSE), 512'h0);
    chk("reset_freq", 512'(FREQ), 512'h0);
    chk("reset_glob2", GLOBAL_REG, 512'h0);
    idle();
    idle();
    chk("reset_apply_never", 512'(APPLY_PULSE), 512'h0);
    rd_chk(17, 32'h0, "status_after_reset");
    rd_chk(45, 32'h0, "shadow_after_reset");
    wr(48, 4'hF, 32'hFFFFFFFF);
    rd_chk(48, 32'h0, "addr48_unmapped");

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int a;
      a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 49));
      step($urandom_range(0, 79) == 0, $urandom_range(0, 5) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, a, 4'($urandom),
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
